// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: per-key synchroniser, stable-sample filter, press/release
// pulses and long-press detection with optional auto-repeat, all on the slow scan clock.
module key_debounce_multi #(
    parameter int N_KEYS        = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int LONG_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 0,
    parameter int ACTIVE_HIGH   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_debounced,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] LONG_SAT    = HW'(LONG_CYCLES);
    localparam bit            REPEAT_EN   = (REPEAT_CYCLES > 0);
    // Pulses fire when the counter sits at LONG_LAST, so reloading to LONG-REPEAT
    // puts the next pulse exactly REPEAT_CYCLES later.
    localparam logic [HW-1:0] RELOAD = (REPEAT_CYCLES >= LONG_CYCLES) ? '0
                                     : HW'(LONG_CYCLES - REPEAT_CYCLES);

    logic [N_KEYS-1:0] key_norm;
    logic [N_KEYS-1:0] sync_s1;
    logic [N_KEYS-1:0] sync_s2;

    assign key_norm = (ACTIVE_HIGH != 0) ? key : ~key;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= key_norm;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        logic [SW-1:0] stable_cnt;
        logic [HW-1:0] hold_cnt;
        logic          deb_q;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          toggle;

        assign toggle = (sync_s2[i] != deb_q) && (stable_cnt == STABLE_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stable_cnt <= '0;
                hold_cnt   <= '0;
                deb_q      <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                press_q   <= toggle && !deb_q;
                release_q <= toggle && deb_q;
                long_q    <= 1'b0;

                if (sync_s2[i] == deb_q) begin
                    stable_cnt <= '0;
                end else if (toggle) begin
                    deb_q      <= ~deb_q;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end

                // The toggle edge also covers release, so no long pulse can
                // coincide with the falling edge of the debounced level.
                if (!deb_q || toggle) begin
                    hold_cnt <= '0;
                end else if (hold_cnt == LONG_LAST) begin
                    long_q   <= 1'b1;
                    hold_cnt <= REPEAT_EN ? RELOAD : LONG_SAT;
                end else if (hold_cnt != LONG_SAT) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end

        assign key_debounced[i] = deb_q;
        assign key_press[i]     = press_q;
        assign key_release[i]   = release_q;
        assign key_long[i]      = long_q;
    end

endmodule
